// File: rtl/pong_score_controller_if.sv
// Purpose: groups the match-control inputs (point/start/frame pulses, divided
//          column) and the score/display outputs of pong_score_controller.
// Modports:
//   master - drives the i_* pulses and column, observes the o_* outputs
//   slave  - the score controller itself
interface pong_score_controller_if;
  logic       i_Game_Start;
  logic       i_P1_Point;
  logic       i_P2_Point;
  logic       i_Frame_Tick;
  logic [5:0] i_ColCount_Div;
  logic [3:0] o_P1_Score;
  logic [3:0] o_P2_Score;
  logic       o_Game_Active;
  logic       o_Ball_Hold;
  logic [1:0] o_Winner;
  logic [3:0] o_ScoreCount;
  logic [1:0] o_Digit_Col;
  logic       o_Score_En;

  modport master (
    output i_Game_Start, i_P1_Point, i_P2_Point, i_Frame_Tick, i_ColCount_Div,
    input  o_P1_Score, o_P2_Score, o_Game_Active, o_Ball_Hold, o_Winner,
           o_ScoreCount, o_Digit_Col, o_Score_En
  );

  modport slave (
    input  i_Game_Start, i_P1_Point, i_P2_Point, i_Frame_Tick, i_ColCount_Div,
    output o_P1_Score, o_P2_Score, o_Game_Active, o_Ball_Hold, o_Winner,
           o_ScoreCount, o_Digit_Col, o_Score_En
  );
endinterface

// File: rtl/pong_score_controller.sv
// Purpose: Pong match state - two 4-bit scores, post-point serve hold, win
//          detection with a blinking winner digit, and a column-region mux that
//          time-shares one score renderer between the P1 and P2 digits.
// Ports:
//   i_Clk  - system/pixel clock
//   i_Rst  - asynchronous active-high reset
//   bus    - pong_score_controller_if.slave (pulses, column in; scores, hold,
//            winner and renderer controls out; all outputs registered)
//
// state        | meaning
// S_IDLE       | waiting for the first start, ball parked
// S_PLAYING    | rally in progress, points counted
// S_POINT_HOLD | ball parked for a fixed number of frames after a point
// S_GAME_OVER  | scores frozen, winner digit blinks until restart
module pong_score_controller #(
  parameter int c_SCORE_LIMIT       = 9,
  parameter int c_POINT_HOLD_FRAMES = 60,
  parameter int c_BLINK_FRAMES      = 30,
  parameter int c_P1_SCORE_X_POS    = 10,
  parameter int c_P2_SCORE_X_POS    = 27
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst,
  pong_score_controller_if.slave   bus
);

  localparam logic [3:0] lc_LIMIT = 4'(c_SCORE_LIMIT);
  localparam logic [7:0] lc_HOLD  = 8'(c_POINT_HOLD_FRAMES);
  localparam logic [7:0] lc_BLINK = 8'(c_BLINK_FRAMES);
  localparam logic [5:0] lc_P1_X  = 6'(c_P1_SCORE_X_POS);
  localparam logic [5:0] lc_P2_X  = 6'(c_P2_SCORE_X_POS);

  typedef enum logic [1:0] {S_IDLE, S_PLAYING, S_POINT_HOLD, S_GAME_OVER} t_state;

  t_state     r_state, w_state;
  logic [3:0] r_p1, w_p1, r_p2, w_p2;
  logic [1:0] r_winner, w_winner;
  logic [7:0] r_hold_cnt, w_hold_cnt;
  logic [7:0] r_blink_cnt, w_blink_cnt;
  logic       r_blink_on, w_blink_on;
  logic       r_game_active, r_ball_hold;
  logic [3:0] r_score_count, w_score_count;
  logic [1:0] r_digit_col, w_digit_col;
  logic       r_score_en, w_score_en;
  logic       w_in_p1, w_in_p2, w_blank_p1, w_blank_p2;

  always_comb begin
    w_state     = r_state;
    w_p1        = r_p1;
    w_p2        = r_p2;
    w_winner    = r_winner;
    w_hold_cnt  = r_hold_cnt;
    w_blink_cnt = r_blink_cnt;
    w_blink_on  = r_blink_on;
    case (r_state)
      S_IDLE: begin
        if (bus.i_Game_Start) begin
          w_state  = S_PLAYING;
          w_p1     = '0;
          w_p2     = '0;
          w_winner = 2'b00;
        end
      end
      S_PLAYING: begin
        if (bus.i_P1_Point && bus.i_P2_Point) begin
          w_state    = S_POINT_HOLD;
          w_hold_cnt = lc_HOLD;
        end else if (bus.i_P1_Point || bus.i_P2_Point) begin
          if (bus.i_P1_Point) w_p1 = r_p1 + 4'd1;
          else                w_p2 = r_p2 + 4'd1;
          if ((bus.i_P1_Point && w_p1 == lc_LIMIT) || (bus.i_P2_Point && w_p2 == lc_LIMIT)) begin
            w_state     = S_GAME_OVER;
            w_winner    = bus.i_P1_Point ? 2'b01 : 2'b10;
            w_blink_cnt = lc_BLINK;
            w_blink_on  = 1'b1;
          end else begin
            w_state    = S_POINT_HOLD;
            w_hold_cnt = lc_HOLD;
          end
        end
      end
      S_POINT_HOLD: begin
        if (bus.i_Frame_Tick) begin
          if (r_hold_cnt <= 8'd1) begin
            w_hold_cnt = '0;
            w_state    = S_PLAYING;
          end else begin
            w_hold_cnt = r_hold_cnt - 8'd1;
          end
        end
      end
      S_GAME_OVER: begin
        if (bus.i_Game_Start) begin
          w_state     = S_PLAYING;
          w_p1        = '0;
          w_p2        = '0;
          w_winner    = 2'b00;
          w_blink_on  = 1'b1;
          w_blink_cnt = '0;
        end else if (bus.i_Frame_Tick) begin
          if (r_blink_cnt <= 8'd1) begin
            w_blink_cnt = lc_BLINK;
            w_blink_on  = ~r_blink_on;
          end else begin
            w_blink_cnt = r_blink_cnt - 8'd1;
          end
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  // The mux looks at next-state values so the digit shown always matches the
  // score being registered on the same edge.
  always_comb begin
    w_in_p1    = (bus.i_ColCount_Div >= lc_P1_X) && (bus.i_ColCount_Div < lc_P1_X + 6'd3);
    w_in_p2    = (bus.i_ColCount_Div >= lc_P2_X) && (bus.i_ColCount_Div < lc_P2_X + 6'd3);
    w_blank_p1 = (w_state == S_GAME_OVER) && (w_winner == 2'b01) && !w_blink_on;
    w_blank_p2 = (w_state == S_GAME_OVER) && (w_winner == 2'b10) && !w_blink_on;
    w_score_count = '0;
    w_digit_col   = '0;
    w_score_en    = 1'b0;
    if (w_in_p1) begin
      w_score_count = w_p1;
      w_digit_col   = 2'(bus.i_ColCount_Div - lc_P1_X);
      w_score_en    = !w_blank_p1;
    end else if (w_in_p2) begin
      w_score_count = w_p2;
      w_digit_col   = 2'(bus.i_ColCount_Div - lc_P2_X);
      w_score_en    = !w_blank_p2;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_state       <= S_IDLE;
      r_p1          <= '0;
      r_p2          <= '0;
      r_winner      <= 2'b00;
      r_hold_cnt    <= '0;
      r_blink_cnt   <= '0;
      r_blink_on    <= 1'b1;
      r_game_active <= 1'b0;
      r_ball_hold   <= 1'b1;
      r_score_count <= '0;
      r_digit_col   <= '0;
      r_score_en    <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_p1          <= w_p1;
      r_p2          <= w_p2;
      r_winner      <= w_winner;
      r_hold_cnt    <= w_hold_cnt;
      r_blink_cnt   <= w_blink_cnt;
      r_blink_on    <= w_blink_on;
      r_game_active <= (w_state == S_PLAYING) || (w_state == S_POINT_HOLD);
      r_ball_hold   <= (w_state != S_PLAYING);
      r_score_count <= w_score_count;
      r_digit_col   <= w_digit_col;
      r_score_en    <= w_score_en;
    end
  end

  assign bus.o_P1_Score    = r_p1;
  assign bus.o_P2_Score    = r_p2;
  assign bus.o_Game_Active = r_game_active;
  assign bus.o_Ball_Hold   = r_ball_hold;
  assign bus.o_Winner      = r_winner;
  assign bus.o_ScoreCount  = r_score_count;
  assign bus.o_Digit_Col   = r_digit_col;
  assign bus.o_Score_En    = r_score_en;

endmodule
